// File: rtl/cp0_timer_int.sv
// -----------------------------------------------------------------------------
// cp0_timer_int
//
// Interrupt source block that sits beside the CP0 register file. It owns the
// CP0 Count (reg 9) and Compare (reg 11) registers. It raises the timer
// interrupt on a Count/Compare match. It also synchronises the five
// asynchronous external interrupt lines. The resulting 6-bit vector feeds
// Cause.IP[15:10].
//
// Build option:
//   CP0_TIMER_FULLRATE_EN - when defined, Count advances every clock.
//                           When undefined (default), Count advances every
//                           second clock through a 1-bit tick divider.
//                           Match, pending and read behaviour do not change.
//
// Parameters:
//   SYNC_STAGES  - flops per external-interrupt synchroniser (legal 2..3)
//   COMPARE_RST  - Compare reset value; all-ones keeps the timer quiet
//                  after reset
//
// Ports:
//   cpu_clk_50M      in   1   system clock, all state on its rising edge
//   cpu_rst          in   1   synchronous reset, active-high
//   we               in   1   CP0 write enable (mtc0)
//   waddr            in   5   CP0 write register number
//   wdata            in  32   CP0 write data
//   re               in   1   CP0 read enable (mfc0)
//   raddr            in   5   CP0 read register number
//   ext_int_i        in   5   async external interrupt requests, level, high
//   int_o            out  6   [4:0] synchronised external lines,
//                             [5] timer pending
//   data_o           out 32   combinational read data for Count/Compare
//   timer_pending_o  out  1   copy of int_o[5] (debug / perf counters)
//
// Bus handshake: the mtc0/mfc0 bus has no valid/ready pair. A write takes
// effect on the rising edge where we=1. A read is combinational in the
// cycle where re=1 and returns the pre-edge register value (no write
// bypass). Register numbers other than 9 and 11 are ignored here.
// -----------------------------------------------------------------------------
module cp0_timer_int #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re,
  input  logic [4:0]  raddr,
  input  logic [4:0]  ext_int_i,
  output logic [5:0]  int_o,
  output logic [31:0] data_o,
  output logic        timer_pending_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_pending_q;
  logic        count_inc;
  logic        count_we;
  logic        compare_we;
  logic        match;

  // One row per stage; row SYNC_STAGES-1 is the synchronised output.
  logic [SYNC_STAGES-1:0][4:0] sync_q;

  assign count_we   = we && (waddr == REG_COUNT);
  assign compare_we = we && (waddr == REG_COMPARE);

  // Registered-vs-registered compare. The pending flop adds one edge of
  // latency. This keeps int_o free of any combinational path from inputs.
  assign match = (count_q == compare_q);

  // ---------------------------------------------------------------------------
  // Count rate
  // ---------------------------------------------------------------------------
`ifdef CP0_TIMER_FULLRATE_EN
  // Full-rate build: no divider, Count advances on every edge.
  assign count_inc = 1'b1;
`else
  logic tick_q;

  // Divide-by-2 toggle. A Count write restarts the phase. This makes the
  // first increment after a write land exactly two edges later.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      tick_q <= 1'b0;
    end else if (count_we) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= ~tick_q;
    end
  end

  assign count_inc = tick_q;
`endif

  // ---------------------------------------------------------------------------
  // Count register: a write overrides the increment. Count wraps silently.
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      count_q <= 32'd0;
    end else if (count_we) begin
      count_q <= wdata;
    end else if (count_inc) begin
      count_q <= count_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare register
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      compare_q <= COMPARE_RST;
    end else if (compare_we) begin
      compare_q <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Timer pending: sticky once set. A Compare write clears it. The clear
  // wins over a match seen in the same cycle. This is the software
  // acknowledge path.
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      timer_pending_q <= 1'b0;
    end else if (compare_we) begin
      timer_pending_q <= 1'b0;
    end else if (match) begin
      timer_pending_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // External interrupt synchronisers. Lines are level-sensitive with no
  // latching. A pulse shorter than a clock period may be missed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= ext_int_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign int_o           = {timer_pending_q, sync_q[SYNC_STAGES-1]};
  assign timer_pending_o = timer_pending_q;

  // ---------------------------------------------------------------------------
  // Read mux: forced to zero during reset so mfc0 never sees stale state.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_o = 32'd0;
    if (!cpu_rst && re) begin
      case (raddr)
        REG_COUNT:   data_o = count_q;
        REG_COMPARE: data_o = compare_q;
        default:     data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_timer_int.sv
// -----------------------------------------------------------------------------
// tb_cp0_timer_int
//
// Bench for cp0_timer_int. Each scenario is a task. A task pushes the
// expected value to exp_q when it drives stimulus. It pops and compares
// that value once the DUT has taken the clock edge. Outputs are sampled
// 1 time unit after the rising edge. Expected Count values come from the
// number of edges since the last Count write. DIV is 2 in the default
// build and 1 in the full-rate build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cp0_timer_int;

  localparam int SYNC = 2;
`ifdef CP0_TIMER_FULLRATE_EN
  localparam int DIV = 1;
`else
  localparam int DIV = 2;
`endif

  logic        cpu_clk_50M;
  logic        cpu_rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [4:0]  raddr;
  logic [4:0]  ext_int_i;
  logic [5:0]  int_o;
  logic [31:0] data_o;
  logic        timer_pending_o;

  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] rd;
  int          n_checks;
  int          n_fail;

  cp0_timer_int #(
    .SYNC_STAGES(SYNC),
    .COMPARE_RST(32'hFFFF_FFFF)
  ) dut (
    .cpu_clk_50M    (cpu_clk_50M),
    .cpu_rst        (cpu_rst),
    .we             (we),
    .waddr          (waddr),
    .wdata          (wdata),
    .re             (re),
    .raddr          (raddr),
    .ext_int_i      (ext_int_i),
    .int_o          (int_o),
    .data_o         (data_o),
    .timer_pending_o(timer_pending_o)
  );

  // ---------------- clock / reset -----------------
  initial cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks -----------------
  task automatic step();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
    we    = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
    re    = 1'b1;
    raddr = a;
    #1;
    d     = data_o;
    re    = 1'b0;
  endtask

  // ---------------- scenarios -----------------
  task automatic test_reset();
    cpu_rst   = 1'b1;
    we        = 1'b1;
    waddr     = 5'd11;
    wdata     = 32'h1234_5678;
    ext_int_i = 5'h1F;
    repeat (3) step();
    exp_q.push_back(32'd0);
    read_reg(5'd11, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL reset_data_o_during_rst: got %h expected %h", rd, exp); end
    cpu_rst   = 1'b0;
    we        = 1'b0;
    ext_int_i = 5'h00;
    exp_q.push_back(32'd0);
    read_reg(5'd9, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL reset_count: got %h expected %h", rd, exp); end
    exp_q.push_back(32'hFFFF_FFFF);
    read_reg(5'd11, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL reset_compare: got %h expected %h", rd, exp); end
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_checks++;
    if ({25'd0, timer_pending_o, int_o} !== exp) begin
      n_fail++; $display("FAIL reset_int_o: got %h/%b expected 0", int_o, timer_pending_o);
    end
  endtask

  task automatic test_timer_match();
    write_reg(5'd11, 32'd10);
    write_reg(5'd9, 32'd0);
    for (int n = 1; n <= 10*DIV + 1; n++) begin
      exp_q.push_back(32'(n / DIV));
      exp_q.push_back({31'd0, n >= 10*DIV + 1});
      step();
      read_reg(5'd9, rd);
      exp = exp_q.pop_front(); n_checks++;
      if (rd !== exp) begin n_fail++; $display("FAIL match_count n=%0d: got %h expected %h", n, rd, exp); end
      exp = exp_q.pop_front(); n_checks++;
      if ({31'd0, int_o[5]} !== exp) begin n_fail++; $display("FAIL match_pending n=%0d: got %b expected %b", n, int_o[5], exp[0]); end
    end
    for (int k = 0; k < 50; k++) begin
      exp_q.push_back(32'd1);
      step();
      exp = exp_q.pop_front(); n_checks++;
      if ({31'd0, int_o[5] & timer_pending_o} !== exp) begin
        n_fail++; $display("FAIL match_sticky k=%0d: got %b/%b expected 1", k, int_o[5], timer_pending_o);
      end
    end
    // Write Compare=100 while reading Compare: the read must see the old value.
    we = 1'b1; waddr = 5'd11; wdata = 32'd100;
    exp_q.push_back(32'd10);
    re = 1'b1; raddr = 5'd11; #1; rd = data_o; re = 1'b0;
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL read_during_write: got %h expected %h", rd, exp); end
    exp_q.push_back(32'd0);
    step();
    we = 1'b0;
    exp = exp_q.pop_front(); n_checks++;
    if ({31'd0, int_o[5]} !== exp) begin n_fail++; $display("FAIL compare_write_clear: got %b expected 0", int_o[5]); end
    exp_q.push_back(32'd100);
    read_reg(5'd11, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL compare_readback: got %h expected %h", rd, exp); end
  endtask

  task automatic test_clear_priority();
    write_reg(5'd11, 32'd4);
    write_reg(5'd9, 32'd4);
    // count == compare == 4 now. A Compare write this cycle must win.
    exp_q.push_back(32'd0);
    write_reg(5'd11, 32'd5);
    exp = exp_q.pop_front(); n_checks++;
    if ({31'd0, timer_pending_o} !== exp) begin n_fail++; $display("FAIL clear_priority: got %b expected 0", timer_pending_o); end
    for (int n = 2; n <= DIV + 2; n++) begin
      exp_q.push_back(32'(4 + n / DIV));
      exp_q.push_back({31'd0, n >= DIV + 1});
      step();
      read_reg(5'd9, rd);
      exp = exp_q.pop_front(); n_checks++;
      if (rd !== exp) begin n_fail++; $display("FAIL clear_count n=%0d: got %h expected %h", n, rd, exp); end
      exp = exp_q.pop_front(); n_checks++;
      if ({31'd0, timer_pending_o} !== exp) begin n_fail++; $display("FAIL clear_rematch n=%0d: got %b expected %b", n, timer_pending_o, exp[0]); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    write_reg(5'd9, 32'hFFFF_FFFE);
    for (int n = 1; n <= 3*DIV + 1; n++) begin
      e = 32'hFFFF_FFFE + 32'(n / DIV);
      exp_q.push_back(e);
      exp_q.push_back({31'd0, n >= 3*DIV + 1});
      if (n == 1) write_reg(5'd11, 32'd1);
      else        step();
      read_reg(5'd9, rd);
      exp = exp_q.pop_front(); n_checks++;
      if (rd !== exp) begin n_fail++; $display("FAIL wrap_count n=%0d: got %h expected %h", n, rd, exp); end
      exp = exp_q.pop_front(); n_checks++;
      if ({31'd0, int_o[5]} !== exp) begin n_fail++; $display("FAIL wrap_pending n=%0d: got %b expected %b", n, int_o[5], exp[0]); end
    end
  endtask

  task automatic test_ext_sync();
    step();
    #($urandom_range(0, 15));
    ext_int_i[2] = 1'b1;
    for (int k = 1; k <= SYNC + 1; k++) begin
      exp_q.push_back((k >= SYNC) ? 32'h04 : 32'h00);
      step();
      exp = exp_q.pop_front(); n_checks++;
      if ({27'd0, int_o[4:0]} !== exp) begin n_fail++; $display("FAIL ext_rise k=%0d: got %b expected %b", k, int_o[4:0], exp[4:0]); end
    end
    #($urandom_range(0, 15));
    ext_int_i[2] = 1'b0;
    for (int k = 1; k <= SYNC + 1; k++) begin
      exp_q.push_back((k >= SYNC) ? 32'h00 : 32'h04);
      step();
      exp = exp_q.pop_front(); n_checks++;
      if ({27'd0, int_o[4:0]} !== exp) begin n_fail++; $display("FAIL ext_fall k=%0d: got %b expected %b", k, int_o[4:0], exp[4:0]); end
    end
    exp_q.push_back(32'd0);
    read_reg(5'd12, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL read_other_reg: got %h expected %h", rd, exp); end
    exp_q.push_back(32'd0);
    raddr = 5'd9; re = 1'b0; #1;
    exp = exp_q.pop_front(); n_checks++;
    if (data_o !== exp) begin n_fail++; $display("FAIL read_re_low: got %h expected %h", data_o, exp); end
  endtask

  task automatic test_ext_random();
    logic [4:0] v;
    ext_int_i = 5'h00;
    repeat (SYNC + 1) step();
    for (int i = 0; i < SYNC - 1; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 24; i++) begin
      v = 5'($urandom_range(0, 31));
      ext_int_i = v;
      exp_q.push_back({27'd0, v});
      step();
      exp = exp_q.pop_front(); n_checks++;
      if ({27'd0, int_o[4:0]} !== exp) begin n_fail++; $display("FAIL ext_random i=%0d: got %b expected %b", i, int_o[4:0], exp[4:0]); end
    end
    exp_q.delete();
    ext_int_i = 5'h00;
  endtask

  task automatic test_reset_mid();
    write_reg(5'd11, 32'h56);
    write_reg(5'd9, 32'h55);
    ext_int_i = 5'h1F;
    repeat (6) step();
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); n_checks++;
    if ({31'd0, timer_pending_o} !== exp) begin n_fail++; $display("FAIL mid_pre_pending: got %b expected 1", timer_pending_o); end
    cpu_rst = 1'b1;
    we = 1'b1; waddr = 5'd9; wdata = 32'hABCD;
    exp_q.push_back(32'd0);
    read_reg(5'd9, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL mid_data_o_in_rst: got %h expected %h", rd, exp); end
    step();
    cpu_rst = 1'b0; we = 1'b0; ext_int_i = 5'h00;
    exp_q.push_back(32'd0);
    read_reg(5'd9, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL mid_count: got %h expected %h", rd, exp); end
    exp_q.push_back(32'hFFFF_FFFF);
    read_reg(5'd11, rd);
    exp = exp_q.pop_front(); n_checks++;
    if (rd !== exp) begin n_fail++; $display("FAIL mid_compare: got %h expected %h", rd, exp); end
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_checks++;
    if ({26'd0, int_o} !== exp) begin n_fail++; $display("FAIL mid_int_o: got %b expected 0", int_o); end
  endtask

  // ---------------- sequence + report -----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cpu_rst   = 1'b1;
    we        = 1'b0;
    waddr     = 5'd0;
    wdata     = 32'd0;
    re        = 1'b0;
    raddr     = 5'd0;
    ext_int_i = 5'd0;
    test_reset();
    test_timer_match();
    test_clear_priority();
    test_wrap();
    test_ext_sync();
    test_ext_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_timer_int.md
Name: cp0_timer_int

Overview:
- Interrupt source block feeding the CP0 register file's 6-bit interrupt input (Cause IP bits 15:10).
- Holds the CP0 Count (reg 9) and Compare (reg 11) registers and raises the timer interrupt on a Count/Compare match.
- Synchronises five asynchronous external interrupt lines.
- Sits beside the CP0 register file and shares the MEM/WB-stage CP0 read/write bus (mfc0/mtc0) with it.

Parameters:
- SYNC_STAGES, 2, number of flops in each external-interrupt synchroniser (legal 2..3).
- COMPARE_RST, 32'hFFFF_FFFF, Compare reset value, so no timer interrupt fires right after reset.

Ports:
- cpu_clk_50M  in  1  system clock, all state on its rising edge.
- cpu_rst  in  1  synchronous reset, active-high.
- we  in  1  CP0 write enable (mtc0).
- waddr  in  5  CP0 write register number.
- wdata  in  32  CP0 write data.
- re  in  1  CP0 read enable (mfc0).
- raddr  in  5  CP0 read register number.
- ext_int_i  in  5  asynchronous external interrupt requests, level, active-high.
- int_o  out  6  interrupt vector to CP0: [4:0] synchronised external lines, [5] timer pending.
- data_o  out  32  read data for Count/Compare.
- timer_pending_o  out  1  copy of int_o[5], for debug/perf counters.

Behaviour:
- Interface: one clock `cpu_clk_50M`; reset `cpu_rst` is synchronous and active-high.
- Reset values:
  - count = 0, compare = COMPARE_RST, tick = 0, timer_pending = 0.
  - All synchroniser flops = 0, so int_o = 6'b0 and timer_pending_o = 0.
  - data_o = 0 while cpu_rst = 1.
- Tick divider: a 1-bit toggle flop; count increments by 1 on each edge where tick = 1 (every second cycle). Count wraps 32'hFFFF_FFFF -> 0 with no flag.
- Count write (we = 1, waddr = 9):
  - count <= wdata; tick <= 0.
  - The write overrides the increment in the same cycle.
- Compare write (we = 1, waddr = 11):
  - compare <= wdata; timer_pending <= 0.
  - The clear has priority over a match detected in the same cycle.
- Match:
  - Compare registered values: count == compare.
  - If they match and there is no Compare write this cycle, timer_pending <= 1 on the next edge.
  - Sticky: stays set while count moves on; cleared only by a Compare write or reset.
- Writes to any other waddr are ignored by this block; the CP0 register file handles them.
- External path:
  - Each ext_int_i bit passes through a SYNC_STAGES-flop chain.
  - int_o[4:0] = last stage; latency SYNC_STAGES cycles from input to int_o.
  - Level-sensitive, no latching; a pulse shorter than one cycle may be lost.
- int_o[5] = timer_pending (registered, no combinational path from inputs).
- Read (combinational):
  - data_o = count if re = 1 and raddr = 9.
  - data_o = compare if re = 1 and raddr = 11.
  - data_o = 0 otherwise.
  - A read in the same cycle as a write returns the old value; no bypass.
- Simultaneous Count write and Compare write cannot occur (single write port).
- Reset mid-operation clears all state on the next edge regardless of we.

Optional Feature:
- Macro: CP0_TIMER_FULLRATE_EN.
- Defined: the tick divider is removed; count increments every cycle, and a Count write does not touch tick.
- Undefined: divide-by-2 tick as described above (MIPS32 default).
- Match, pending and read behaviour are identical in both builds.

Test Plan:
- Reset: hold cpu_rst 3 cycles, release -> count reads 0, compare reads 32'hFFFF_FFFF, int_o = 6'b0.
- Timer match: write Compare = 10 at t0, Count = 0 at t0+1 -> count reaches 10 about 20 cycles later; int_o[5] rises the edge after the match and stays 1 for 50 further cycles; write Compare = 100 -> int_o[5] = 0 next cycle.
- Clear priority: write Compare = 5 in the same cycle count == old compare = 4 -> timer_pending stays 0.
- Wrap: write Count = 32'hFFFF_FFFE, Compare = 1 -> count goes FFFF_FFFF, 0, 1; pending sets after count == 1.
- External sync: raise ext_int_i[2] at an arbitrary phase -> int_o[2] = 1 exactly SYNC_STAGES edges later; drop it -> int_o[2] = 0 SYNC_STAGES edges later; re = 1, raddr = 12 -> data_o = 0.
- Full-rate build (CP0_TIMER_FULLRATE_EN): write Count = 0, Compare = 8 -> int_o[5] = 1 nine edges after the Count write.
